// File: rtl/dbus_slave_decoder.sv
// Address decoder between the data-bus arbiter and four peripheral slaves.
// Locks the chosen slave per transaction; unmapped or hung accesses end in an error response.
module dbus_slave_decoder #(
    parameter logic [31:0] BASE0    = 32'h0000_0000,
    parameter logic [31:0] MASK0    = 32'hF000_0000,
    parameter logic [31:0] BASE1    = 32'h1FC0_0000,
    parameter logic [31:0] MASK1    = 32'hFFFF_0000,
    parameter logic [31:0] BASE2    = 32'h1FD0_0000,
    parameter logic [31:0] MASK2    = 32'hFFFF_0000,
    parameter logic [31:0] BASE3    = 32'h1FE0_0000,
    parameter logic [31:0] MASK3    = 32'hFFE0_0000,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  addrM,
    input  logic [31:0]  doutM,
    input  logic         stbM,
    input  logic         weM,
    input  logic [3:0]   dmM,
    output logic [31:0]  dinM,
    output logic         nakM,
    output logic [31:0]  addrS,
    output logic [31:0]  dinS,
    output logic         weS,
    output logic [3:0]   dmS,
    output logic [3:0]   stbS,
    input  logic [127:0] doutS,
    input  logic [3:0]   nakS,
    input  logic         errClr,
    output logic         errFlag,
    output logic [1:0]   errCause,
    output logic [31:0]  errAddr
);
    localparam int              CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

    state_t          r_state;
    logic [1:0]      r_sel;
    logic [CW-1:0]   r_cnt;
    logic            r_errFlag;
    logic [1:0]      r_errCause;
    logic [31:0]     r_errAddr;

    logic [3:0]      w_hit;
    logic            w_any;
    logic [1:0]      w_idx;
    logic            w_timeout;

    assign addrS = addrM;
    assign dinS  = doutM;
    assign weS   = weM;
    assign dmS   = dmM;

    assign w_hit[0] = (addrM & MASK0) == BASE0;
    assign w_hit[1] = (addrM & MASK1) == BASE1;
    assign w_hit[2] = (addrM & MASK2) == BASE2;
    assign w_hit[3] = (addrM & MASK3) == BASE3;
    assign w_any    = |w_hit;

    always_comb begin
        w_idx = 2'd0;
        if (w_hit[0])      w_idx = 2'd0;
        else if (w_hit[1]) w_idx = 2'd1;
        else if (w_hit[2]) w_idx = 2'd2;
        else if (w_hit[3]) w_idx = 2'd3;
    end

    // Abort only when the locked slave is still stalling on its last allowed cycle.
    assign w_timeout = (r_state == S_BUSY) && stbM && nakS[r_sel] && (r_cnt == CNT_MAX);

    always_comb begin
        stbS = 4'b0000;
        nakM = 1'b0;
        dinM = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_any) dinM = doutS[32*w_idx +: 32];
                if (stbM) begin
                    if (w_any) begin
                        stbS[w_idx] = 1'b1;
                        nakM        = nakS[w_idx];
                    end else begin
                        nakM = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                dinM = doutS[32*r_sel +: 32];
                if (w_timeout) begin
                    dinM = ERR_DATA;
                end else if (stbM) begin
                    stbS[r_sel] = 1'b1;
                    nakM        = nakS[r_sel];
                end
            end
            S_ERR:   dinM = ERR_DATA;
            default: dinM = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 2'd0;
            r_cnt      <= '0;
            r_errFlag  <= 1'b0;
            r_errCause <= 2'b00;
            r_errAddr  <= 32'h0;
        end else begin
            // Error captures below are later assignments, so they override a same-cycle clear.
            if (errClr) begin
                r_errFlag  <= 1'b0;
                r_errCause <= 2'b00;
            end
            case (r_state)
                S_IDLE: begin
                    if (stbM && w_any && nakS[w_idx]) begin
                        r_sel   <= w_idx;
                        r_cnt   <= CW'(1);
                        r_state <= S_BUSY;
                    end else if (stbM && !w_any) begin
                        r_state <= S_ERR;
                    end
                end
                S_BUSY: begin
                    if (!stbM || !nakS[r_sel]) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_cnt      <= '0;
                        r_state    <= S_IDLE;
                        r_errFlag  <= 1'b1;
                        r_errCause <= 2'b10;
                        r_errAddr  <= addrM;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_ERR: begin
                    r_errFlag  <= 1'b1;
                    r_errCause <= 2'b01;
                    r_errAddr  <= addrM;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign errFlag  = r_errFlag;
    assign errCause = r_errCause;
    assign errAddr  = r_errAddr;

endmodule

// File: tb/tb_dbus_slave_decoder.sv
// Randomized transaction-level bench for dbus_slave_decoder (TIMEOUT reduced to 4).
module tb_dbus_slave_decoder;
    localparam int TO = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic         clk, rst;
    logic [31:0]  addrM, doutM, dinM, addrS, dinS, errAddr;
    logic         stbM, weM, nakM, weS, errClr, errFlag;
    logic [3:0]   dmM, dmS, stbS, nakS;
    logic [127:0] doutS;
    logic [1:0]   errCause;

    dbus_slave_decoder #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .addrM(addrM), .doutM(doutM), .stbM(stbM), .weM(weM),
        .dmM(dmM), .dinM(dinM), .nakM(nakM), .addrS(addrS), .dinS(dinS), .weS(weS),
        .dmS(dmS), .stbS(stbS), .doutS(doutS), .nakS(nakS), .errClr(errClr),
        .errFlag(errFlag), .errCause(errCause), .errAddr(errAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_base [4] = '{32'h0000_0000, 32'h1FC0_0000, 32'h1FD0_0000, 32'h1FE0_0000};
    logic [31:0] m_mask [4] = '{32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFE0_0000};

    logic        e_flag;
    logic [1:0]  e_cause;
    logic [31:0] e_addr;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & m_mask[i]) == m_base[i]) return i;
        return -1;
    endfunction

    task automatic drive_slaves(input int tgt, input bit tnak, input logic [31:0] tdata);
        doutS = {$urandom, $urandom, $urandom, $urandom};
        nakS  = 4'($urandom);
        if (tgt >= 0) begin
            doutS[32*tgt +: 32] = tdata;
            nakS[tgt] = tnak;
        end
    endtask

    // One full transaction: slave stalls w cycles; checks every cycle until completion.
    task automatic run_txn(input logic [31:0] a, input bit we, input int w, input bit clr_done);
        int tgt, kdone;
        bit err;
        logic [1:0] cause;
        logic [31:0] data;
        logic [3:0] exp_stb;
        tgt = decode(a);
        data = $urandom;
        err = 1'b0;
        cause = 2'b00;
        if (tgt < 0) begin
            kdone = 1; err = 1'b1; cause = 2'b01;
        end else if (w <= TO) begin
            kdone = w;
        end else begin
            kdone = TO; err = 1'b1; cause = 2'b10;
        end
        addrM = a; weM = we; doutM = $urandom; dmM = 4'($urandom); stbM = 1'b1;
        for (int c = 0; c <= kdone; c++) begin
            drive_slaves(tgt, c < w, data);
            errClr = (c == kdone) && clr_done;
            #4;
            exp_stb = (tgt < 0 || (err && c == kdone)) ? 4'b0000 : (4'b0001 << tgt);
            chk("stbS", stbS, exp_stb);
            chk("nakM", nakM, c != kdone);
            if (c == kdone) chk("dinM", dinM, err ? ERRD : data);
            if (c == 0) chk("passthru", {addrS, dinS, weS, dmS}, {addrM, doutM, weM, dmM});
            @(posedge clk); #1;
        end
        stbM = 1'b0; errClr = 1'b0;
        if (err) begin
            e_flag = 1'b1; e_cause = cause; e_addr = a;
        end else if (clr_done) begin
            e_flag = 1'b0; e_cause = 2'b00;
        end
    endtask

    // Strobe n cycles into a stalling slave without letting it finish.
    task automatic start_partial(input logic [31:0] a, input int n);
        int tgt;
        tgt = decode(a);
        addrM = a; weM = 1'b0; stbM = 1'b1; errClr = 1'b0;
        for (int c = 0; c < n; c++) begin
            drive_slaves(tgt, 1'b1, $urandom);
            #4;
            chk("p_stbS", stbS, 4'b0001 << tgt);
            chk("p_nakM", nakM, 1'b1);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input bit clr);
        stbM = 1'b0; errClr = clr;
        drive_slaves(-1, 1'b0, 32'h0);
        #4;
        chk("i_nakM", nakM, 1'b0);
        chk("i_stbS", stbS, 4'b0000);
        chk("errFlag", errFlag, e_flag);
        chk("errCause", errCause, e_cause);
        chk("errAddr", errAddr, e_addr);
        @(posedge clk); #1;
        if (clr) begin
            e_flag = 1'b0; e_cause = 2'b00;
        end
        errClr = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr(input int cat);
        logic [31:0] r;
        r = $urandom;
        case (cat)
            0:       return {4'h0, r[27:0]};
            1:       return {16'h1FC0, r[15:0]};
            2:       return {16'h1FD0, r[15:0]};
            3:       return {11'b0001_1111_111, r[20:0]};
            default: return {4'($urandom_range(2, 15)), r[27:0]};
        endcase
    endfunction

    initial begin
        rst = 1'b1; stbM = 1'b0; weM = 1'b0; addrM = '0; doutM = '0; dmM = '0;
        errClr = 1'b0; nakS = '0; doutS = '0;
        e_flag = 1'b0; e_cause = 2'b00; e_addr = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        #4;
        chk("rst_errFlag", errFlag, 1'b0);
        chk("rst_errCause", errCause, 2'b00);
        chk("rst_errAddr", errAddr, 32'h0);
        chk("rst_nakM", nakM, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn(32'h0000_1000, 1'b0, 0, 1'b0);
        idle(1'b0);
        run_txn(32'h1FD0_0004, 1'b0, 3, 1'b0);
        idle(1'b0);
        run_txn(32'h3000_0000, 1'b1, 0, 1'b0);
        idle(1'b0);
        run_txn(32'h1FE0_0010, 1'b0, TO + 3, 1'b0);
        idle(1'b0);
        run_txn(32'h1FE0_0010, 1'b0, TO, 1'b0);
        idle(1'b0);
        run_txn(32'h4000_0040, 1'b1, 0, 1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Master abandons a stalled access; the next one must decode from scratch.
        start_partial(32'h0000_2000, 2);
        stbM = 1'b0;
        drive_slaves(0, 1'b1, 32'h0);
        #4;
        chk("drop_stbS", stbS, 4'b0000);
        chk("drop_nakM", nakM, 1'b0);
        @(posedge clk); #1;
        run_txn(32'h1FE0_0040, 1'b0, 1, 1'b0);
        idle(1'b0);

        // Reset while locked onto a stalling slave.
        run_txn(32'h5000_0000, 1'b0, 0, 1'b0);
        start_partial(32'h1FC0_0100, 2);
        rst = 1'b1; stbM = 1'b0;
        drive_slaves(1, 1'b1, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        e_flag = 1'b0; e_cause = 2'b00; e_addr = 32'h0;
        idle(1'b0);
        run_txn(32'h1FD0_0008, 1'b0, 2, 1'b0);
        idle(1'b0);

        for (int t = 0; t < 200; t++) begin
            run_txn(rand_addr($urandom_range(0, 4)), 1'($urandom), $urandom_range(0, TO + 2),
                    $urandom_range(0, 3) == 0);
            idle($urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
